// File: rtl/resize_buffer.sv
// Lane-width converter FIFO: packs keep=1 lanes from S-lane writes into a
// circular lane store and emits M-lane reads, with last-driven partial flush.
// Dropped writes and empty reads are reported as one-cycle pulses.
module resize_buffer #(
  parameter int S_KEEP_WIDTH     = 3,
  parameter int M_KEEP_WIDTH     = 2,
  parameter int T_DATA_WIDTH     = 1,
  parameter int DEPTH            = 16,
  parameter int BUF_IN_ENTRY_SZ  = (2 + T_DATA_WIDTH) * S_KEEP_WIDTH,
  parameter int BUF_OUT_ENTRY_SZ = (2 + T_DATA_WIDTH) * M_KEEP_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        slave_entry_valid,
  input  logic [BUF_IN_ENTRY_SZ-1:0]  slave_entry,
  input  logic                        master_entry_ready,
  output logic [BUF_OUT_ENTRY_SZ-1:0] master_entry,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned L  = 2 + T_DATA_WIDTH;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [L-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [BUF_OUT_ENTRY_SZ-1:0] w_rd_data;
  logic [CW-1:0]               w_pop;
  logic                        w_underflow;
  logic                        w_found;
  logic [BUF_IN_ENTRY_SZ-1:0]  w_pack;
  logic [CW-1:0]               w_n;
  logic [CW:0]                 w_space;
  logic                        w_push_ok;
  logic                        w_overflow;

  // Pointer advance modulo DEPTH; offsets are always below DEPTH
  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base,
                                           input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= DEPTH) s = s - DEPTH;
    return s[PW-1:0];
  endfunction

  // Read selection: full M-lane pop, last-terminated partial flush, or underflow
  always_comb begin
    w_rd_data   = '0;
    w_pop       = '0;
    w_underflow = 1'b0;
    w_found     = 1'b0;
    if (master_entry_ready) begin
      if (r_count >= CW'(M_KEEP_WIDTH)) begin
        w_pop = CW'(M_KEEP_WIDTH);
        for (int unsigned j = 0; j < M_KEEP_WIDTH; j++)
          w_rd_data[j*L +: L] = r_mem[f_wrap(r_rd_ptr, j)];
      end else begin
        // Copy stored lanes until the first last=1 lane; a flush without
        // any last lane is discarded and reported as underflow instead.
        for (int unsigned j = 0; j < M_KEEP_WIDTH; j++) begin
          if (!w_found && (CW'(j) < r_count)) begin
            w_rd_data[j*L +: L] = r_mem[f_wrap(r_rd_ptr, j)];
            if (r_mem[f_wrap(r_rd_ptr, j)][L-2]) begin
              w_found = 1'b1;
              w_pop   = CW'(j + 1);
            end
          end
        end
        if (!w_found) begin
          w_rd_data   = '0;
          w_underflow = 1'b1;
        end
      end
    end
  end

  // Write packing: compact keep=1 lanes to the bottom, preserving lane order
  always_comb begin
    w_n    = '0;
    w_pack = '0;
    for (int unsigned i = 0; i < S_KEEP_WIDTH; i++) begin
      if (slave_entry[i*L + L-1]) begin
        w_pack[w_n*L +: L] = slave_entry[i*L +: L];
        w_n = w_n + CW'(1);
      end
    end
  end

  // Admission: same-cycle pop frees space; writes are all-or-nothing
  always_comb begin
    w_space    = (CW+1)'(DEPTH) - {1'b0, r_count} + {1'b0, w_pop};
    w_push_ok  = slave_entry_valid && (w_n != '0) && ({1'b0, w_n} <= w_space);
    w_overflow = slave_entry_valid && ({1'b0, w_n} > w_space);
  end

  // Control state, registered read data and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      master_entry <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      master_entry <= w_rd_data;
      overflow     <= w_overflow;
      underflow    <= w_underflow;
      r_rd_ptr     <= f_wrap(r_rd_ptr, 32'(w_pop));
      if (w_push_ok) r_wr_ptr <= f_wrap(r_wr_ptr, 32'(w_n));
      r_count      <= r_count - w_pop + (w_push_ok ? w_n : '0);
    end
  end

  // Append accepted lanes at the write pointer; lane storage needs no reset
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      for (int unsigned j = 0; j < S_KEEP_WIDTH; j++)
        if (CW'(j) < w_n) r_mem[f_wrap(r_wr_ptr, j)] <= w_pack[j*L +: L];
    end
  end

endmodule

// File: tb/tb_resize_buffer.sv
// Directed bench for resize_buffer at S=3, M=2, T=1, DEPTH=16 (3-bit lanes).
module tb_resize_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       slave_entry_valid;
  logic [8:0] slave_entry;
  logic       master_entry_ready;
  logic [5:0] master_entry;
  logic       overflow;
  logic       underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  resize_buffer #(
    .S_KEEP_WIDTH(3),
    .M_KEEP_WIDTH(2),
    .T_DATA_WIDTH(1),
    .DEPTH(16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .slave_entry_valid (slave_entry_valid),
    .slave_entry       (slave_entry),
    .master_entry_ready(master_entry_ready),
    .master_entry      (master_entry),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; slave_entry_valid = 1'b0; master_entry_ready = 1'b0;
    slave_entry = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; slave_entry_valid = 1'b1; master_entry_ready = 1'b0;
    slave_entry = 9'b101100111;
    tick();
    slave_entry_valid = 1'b0; master_entry_ready = 1'b1;
    tick();
    rst = 1'b0; master_entry_ready = 1'b0;
    total_cnt++;
    if ({master_entry, overflow, underflow} !== 8'b0)
      $display("FAIL reset_outputs: got m=%b ov=%b uf=%b want all 0", master_entry, overflow, underflow);
    else pass_cnt++;
    master_entry_ready = 1'b1;
    tick();
    master_entry_ready = 1'b0;
    total_cnt++;
    if (underflow !== 1'b1 || master_entry !== 6'b0)
      $display("FAIL reset_empty: got m=%b uf=%b want m=000000 uf=1", master_entry, underflow);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    do_reset();
    slave_entry_valid = 1'b1; slave_entry = 9'b101100111;
    tick();
    slave_entry_valid = 1'b0; master_entry_ready = 1'b1;
    tick();
    total_cnt++;
    if (master_entry !== 6'b100111 || underflow !== 1'b0)
      $display("FAIL write_read_data: got m=%b uf=%b want m=100111 uf=0", master_entry, underflow);
    else pass_cnt++;
    tick();
    master_entry_ready = 1'b0;
    total_cnt++;
    if (master_entry !== 6'b0 || underflow !== 1'b1)
      $display("FAIL write_read_leftover: got m=%b uf=%b want m=000000 uf=1", master_entry, underflow);
    else pass_cnt++;
  endtask

  task automatic test_partial_flush();
    do_reset();
    slave_entry_valid = 1'b1; slave_entry = 9'b000000111;
    tick();
    slave_entry_valid = 1'b0; master_entry_ready = 1'b1;
    tick();
    total_cnt++;
    if (master_entry !== 6'b000111 || underflow !== 1'b0)
      $display("FAIL flush_data: got m=%b uf=%b want m=000111 uf=0", master_entry, underflow);
    else pass_cnt++;
    tick();
    master_entry_ready = 1'b0;
    total_cnt++;
    if (master_entry !== 6'b0 || underflow !== 1'b1)
      $display("FAIL flush_empty: got m=%b uf=%b want m=000000 uf=1", master_entry, underflow);
    else pass_cnt++;
  endtask

  task automatic test_keep_gaps();
    do_reset();
    // lane0=100, lane1 keep=0 (dropped), lane2=111
    slave_entry_valid = 1'b1; slave_entry = 9'b111000100;
    tick();
    slave_entry_valid = 1'b0; master_entry_ready = 1'b1;
    tick();
    master_entry_ready = 1'b0;
    total_cnt++;
    if (master_entry !== 6'b111100 || underflow !== 1'b0)
      $display("FAIL keep_gaps: got m=%b uf=%b want m=111100 uf=0", master_entry, underflow);
    else pass_cnt++;
    // keep=0 everywhere with valid: no-op, no overflow
    slave_entry_valid = 1'b1; slave_entry = 9'b011011011;
    tick();
    slave_entry_valid = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0)
      $display("FAIL empty_write_ovf: got ov=%b want 0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [5:0] rp [0:2];
    rp[0] = 6'b100111; rp[1] = 6'b111101; rp[2] = 6'b101100;
    do_reset();
    slave_entry_valid = 1'b1; slave_entry = 9'b101100111;
    for (int e = 1; e <= 6; e++) begin
      tick();
      total_cnt++;
      if (overflow !== (e == 6))
        $display("FAIL overflow_w%0d: got ov=%b want %b", e, overflow, (e == 6));
      else pass_cnt++;
    end
    slave_entry_valid = 1'b0; master_entry_ready = 1'b1;
    for (int r = 0; r < 7; r++) begin
      tick();
      total_cnt++;
      if (master_entry !== rp[r % 3] || underflow !== 1'b0 || overflow !== 1'b0)
        $display("FAIL overflow_drain%0d: got m=%b uf=%b ov=%b want m=%b uf=0 ov=0",
                 r, master_entry, underflow, overflow, rp[r % 3]);
      else pass_cnt++;
    end
    tick();
    master_entry_ready = 1'b0;
    total_cnt++;
    if (master_entry !== 6'b0 || underflow !== 1'b1)
      $display("FAIL overflow_count: got m=%b uf=%b want m=000000 uf=1", master_entry, underflow);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat [0:2];
    logic [5:0] exp_m;
    pat[0] = 6'b100100; pat[1] = 6'b100101; pat[2] = 6'b101100;
    do_reset();
    slave_entry_valid = 1'b1; master_entry_ready = 1'b1; slave_entry = 9'b101100100;
    for (int e = 1; e <= 16; e++) begin
      tick();
      exp_m = (e == 1) ? 6'b0 : pat[(e - 2) % 3];
      total_cnt++;
      if (master_entry !== exp_m || underflow !== (e == 1) || overflow !== (e == 15))
        $display("FAIL stream_c%0d: got m=%b uf=%b ov=%b want m=%b uf=%b ov=%b",
                 e, master_entry, underflow, overflow, exp_m, (e == 1), (e == 15));
      else pass_cnt++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; slave_entry_valid = 1'b0; master_entry_ready = 1'b0;
    total_cnt++;
    if ({master_entry, overflow, underflow} !== 8'b0)
      $display("FAIL midstream_reset: got m=%b ov=%b uf=%b want all 0", master_entry, overflow, underflow);
    else pass_cnt++;
    slave_entry_valid = 1'b1; slave_entry = 9'b101100111;
    tick();
    slave_entry_valid = 1'b0; master_entry_ready = 1'b1;
    tick();
    master_entry_ready = 1'b0;
    total_cnt++;
    if (master_entry !== 6'b100111 || underflow !== 1'b0)
      $display("FAIL after_reset_read: got m=%b uf=%b want m=100111 uf=0", master_entry, underflow);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; slave_entry_valid = 1'b0; master_entry_ready = 1'b0; slave_entry = '0;
    test_reset();
    test_write_read();
    test_partial_flush();
    test_keep_gaps();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
